// File: rtl/fb_arb_pkg.sv
// Shared types and constants for the frame-buffer SDRAM command arbiter.
package fb_arb_pkg;

  localparam int NUM_REQ = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } state_e;

  localparam logic [1:0] REQ_VID  = 2'd0;
  localparam logic [1:0] REQ_CAM  = 2'd1;
  localparam logic [1:0] REQ_HOST = 2'd2;
  localparam logic [1:0] ID_NONE  = 2'd3;

  // First requesting index strictly after ptr, wrapping modulo NUM_REQ.
  function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                         input logic [1:0]         ptr);
    logic [1:0] first, second, third;
    case (ptr)
      REQ_VID: begin first = REQ_CAM;  second = REQ_HOST; third = REQ_VID;  end
      REQ_CAM: begin first = REQ_HOST; second = REQ_VID;  third = REQ_CAM;  end
      default: begin first = REQ_VID;  second = REQ_CAM;  third = REQ_HOST; end
    endcase
    if (req[first])       rr_pick = first;
    else if (req[second]) rr_pick = second;
    else if (req[third])  rr_pick = third;
    else                  rr_pick = ID_NONE;
  endfunction

endpackage

// File: rtl/fb_arb_wait_ctr.sv
// Per-requester saturating wait counter; flags saturation and pulses once on reaching it.
module fb_arb_wait_ctr #(
  parameter int MAX_WAIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic gnt_i,
  output logic at_max_o,
  output logic starve_o
);

  localparam int                CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  MAX_C = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             starve_q, starve_d;

  // NOTE: every variable gets its default before any branch, so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d    = cnt_q;
    starve_d = 1'b0;
    if (!req_i || gnt_i) begin
      cnt_d = '0;
    end else if (cnt_q != MAX_C) begin
      cnt_d    = cnt_q + 1'b1;
      starve_d = (cnt_q == MAX_C - 1'b1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      starve_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

  assign at_max_o = (cnt_q == MAX_C);
  assign starve_o = starve_q;

endmodule

// File: rtl/sdram_fb_arbiter.sv
// Three-way arbiter for the frame-buffer SDRAM command port: urgent scanout first,
// then starved requesters, then round-robin; a watchdog aborts a burst that never completes.
module sdram_fb_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W   = 22,
  parameter int BURST_W  = 5,
  parameter int MAX_WAIT = 64,
  parameter int TIMEOUT  = 1024
) (
  input  logic                       iCLK,
  input  logic                       iRESETn,
  input  logic [NUM_REQ-1:0]         iREQ,
  input  logic [NUM_REQ-1:0]         iWR,
  input  logic [NUM_REQ*ADDR_W-1:0]  iADDR,
  input  logic [NUM_REQ*BURST_W-1:0] iBURST,
  input  logic                       iVID_URGENT,
  output logic [NUM_REQ-1:0]         oGNT,
  output logic [1:0]                 oACTIVE_ID,
  output logic                       oMEM_VALID,
  input  logic                       iMEM_READY,
  output logic [ADDR_W-1:0]          oMEM_ADDR,
  output logic                       oMEM_WR,
  output logic [BURST_W-1:0]         oMEM_BURST,
  input  logic                       iMEM_DONE,
  output logic [NUM_REQ-1:0]         oSTARVE,
  output logic                       oERR
);

  localparam int             WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [1:0]         id_q, id_d;
  logic [1:0]         rr_q, rr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               wr_q, wr_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] gnt, at_max, starved;
  logic [1:0]         win;
  logic [ADDR_W-1:0]  win_addr;
  logic [BURST_W-1:0] win_burst;

  always_comb begin
    gnt = '0;
    if (id_q != ID_NONE) gnt[id_q] = 1'b1;
  end

  for (genvar n = 0; n < NUM_REQ; n++) begin : g_wait
    fb_arb_wait_ctr #(
      .MAX_WAIT (MAX_WAIT)
    ) u_wait (
      .clk      (iCLK),
      .rst_n    (iRESETn),
      .req_i    (iREQ[n]),
      .gnt_i    (gnt[n]),
      .at_max_o (at_max[n]),
      .starve_o (oSTARVE[n])
    );
  end

  // A saturated counter only counts while its request is still present now.
  always_comb begin
    starved = iREQ & at_max;
    win     = rr_pick(iREQ, rr_q);
    if (iREQ[REQ_VID] && iVID_URGENT) win = REQ_VID;
    else if (starved[REQ_VID])        win = REQ_VID;
    else if (starved[REQ_CAM])        win = REQ_CAM;
    else if (starved[REQ_HOST])       win = REQ_HOST;
  end

  assign win_addr  = iADDR[int'(win)*ADDR_W +: ADDR_W];
  assign win_burst = iBURST[int'(win)*BURST_W +: BURST_W];

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    rr_d    = rr_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    burst_d = burst_q;
    wd_d    = wd_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|iREQ) begin
          state_d = ISSUE;
          id_d    = win;
          addr_d  = win_addr;
          wr_d    = iWR[win];
          burst_d = (win_burst == '0) ? BURST_W'(1) : win_burst;
        end
      end
      ISSUE: begin
        if (iMEM_READY) begin
          state_d = BUSY;
          wd_d    = '0;
        end
      end
      BUSY: begin
        if (iMEM_DONE || wd_q == WD_LAST) begin
          state_d = IDLE;
          id_d    = ID_NONE;
          rr_d    = id_q;
          err_d   = !iMEM_DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      state_q <= IDLE;
      id_q    <= ID_NONE;
      rr_q    <= REQ_HOST;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      burst_q <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      burst_q <= burst_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  assign oGNT       = gnt;
  assign oACTIVE_ID = id_q;
  assign oMEM_VALID = (state_q == ISSUE);
  assign oMEM_ADDR  = addr_q;
  assign oMEM_WR    = wr_q;
  assign oMEM_BURST = burst_q;
  assign oERR       = err_q;

endmodule

// File: tb/tb_sdram_fb_arbiter.sv
// Directed scenarios plus randomized traffic, checked every cycle against a transaction-level model.
module tb_sdram_fb_arbiter;

  localparam int ADDR_W  = 22;
  localparam int BURST_W = 5;
  localparam int MW      = 4;
  localparam int TMO     = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rstn;
  logic [2:0]           req, wr;
  logic                 urg, ready, done;
  logic [ADDR_W-1:0]    a [3];
  logic [BURST_W-1:0]   b [3];
  logic [3*ADDR_W-1:0]  addr_flat;
  logic [3*BURST_W-1:0] burst_flat;

  assign addr_flat  = {a[2], a[1], a[0]};
  assign burst_flat = {b[2], b[1], b[0]};

  logic [2:0]         gnt_o, starve_o;
  logic [1:0]         id_o;
  logic               valid_o, wr_o, err_o;
  logic [ADDR_W-1:0]  addr_o;
  logic [BURST_W-1:0] burst_o;

  sdram_fb_arbiter #(
    .ADDR_W   (ADDR_W),
    .BURST_W  (BURST_W),
    .MAX_WAIT (MW),
    .TIMEOUT  (TMO)
  ) dut (
    .iCLK        (clk),
    .iRESETn     (rstn),
    .iREQ        (req),
    .iWR         (wr),
    .iADDR       (addr_flat),
    .iBURST      (burst_flat),
    .iVID_URGENT (urg),
    .oGNT        (gnt_o),
    .oACTIVE_ID  (id_o),
    .oMEM_VALID  (valid_o),
    .iMEM_READY  (ready),
    .oMEM_ADDR   (addr_o),
    .oMEM_WR     (wr_o),
    .oMEM_BURST  (burst_o),
    .iMEM_DONE   (done),
    .oSTARVE     (starve_o),
    .oERR        (err_o)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: phase 0 idle, 1 command offered, 2 burst in flight.
  int                 m_phase, m_id, m_rr, m_busy;
  int                 m_wait [3];
  logic               m_valid, m_wr, m_err;
  logic [ADDR_W-1:0]  m_addr;
  logic [BURST_W-1:0] m_burst;
  logic [2:0]         m_starve;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_id = 3; m_rr = 2; m_busy = 0;
    for (int n = 0; n < 3; n++) m_wait[n] = 0;
    m_valid = 1'b0; m_wr = 1'b0; m_err = 1'b0;
    m_addr = '0; m_burst = '0; m_starve = '0;
  endtask

  function automatic int pick();
    if (req[0] && urg) return 0;
    for (int n = 0; n < 3; n++)
      if (req[n] && m_wait[n] == MW) return n;
    for (int k = 1; k <= 3; k++) begin
      int n = (m_rr + k) % 3;
      if (req[n]) return n;
    end
    return 3;
  endfunction

  task automatic end_txn();
    m_phase = 0;
    m_rr    = m_id;
    m_id    = 3;
  endtask

  task automatic model_step();
    int w;
    if (!rstn) begin
      model_reset();
      return;
    end
    m_err    = 1'b0;
    m_starve = '0;
    w        = pick();
    for (int n = 0; n < 3; n++) begin
      if (req[n] && m_id != n) begin
        if (m_wait[n] < MW) begin
          m_wait[n]++;
          if (m_wait[n] == MW) m_starve[n] = 1'b1;
        end
      end else begin
        m_wait[n] = 0;
      end
    end
    case (m_phase)
      0: if (req != 3'b000) begin
        m_phase = 1; m_id = w; m_valid = 1'b1;
        m_addr  = a[w]; m_wr = wr[w];
        m_burst = (b[w] == '0) ? BURST_W'(1) : b[w];
      end
      1: if (ready) begin
        m_phase = 2; m_valid = 1'b0; m_busy = 0;
      end
      default: begin
        if (done) end_txn();
        else begin
          m_busy++;
          if (m_busy == TMO) begin
            m_err = 1'b1;
            end_txn();
          end
        end
      end
    endcase
  endtask

  task automatic compare_all();
    logic [2:0] eg;
    eg = (m_id == 3) ? 3'b000 : (3'b001 << m_id);
    check("gnt", gnt_o, eg);
    check("active_id", id_o, m_id);
    check("mem_valid", valid_o, m_valid);
    check("mem_addr", addr_o, m_addr);
    check("mem_wr", wr_o, m_wr);
    check("mem_burst", burst_o, m_burst);
    check("starve", starve_o, m_starve);
    check("err", err_o, m_err);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic drain();
    req = '0; urg = 1'b0; ready = 1'b1; done = 1'b1;
    for (int i = 0; i < 8 && m_phase != 0; i++) tick();
    check("drain_idle", id_o, 3);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not reach its summary");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    int ids[$];
    int ts[$];
    int cnt;

    rstn = 1'b1; req = '0; wr = '0; urg = 1'b0; ready = 1'b0; done = 1'b0;
    for (int n = 0; n < 3; n++) begin a[n] = '0; b[n] = '0; end
    model_reset();
    #2 rstn = 1'b0;
    #1;
    compare_all();
    check("rst_active_id", id_o, 3);
    tick();
    rstn = 1'b1;
    tick();

    // Single host write: grant at t+1, command held until READY at t+3, released after DONE at t+12.
    req = 3'b100; wr = 3'b100; a[2] = 22'h00100; b[2] = 5'd8;
    tick();
    check("host_gnt", gnt_o, 3'b100);
    check("host_valid", valid_o, 1'b1);
    check("host_addr", addr_o, 22'h00100);
    check("host_burst", burst_o, 5'd8);
    req = 3'b000;
    tick();
    tick();
    check("host_valid_t3", valid_o, 1'b1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("host_valid_off", valid_o, 1'b0);
    repeat (8) tick();
    check("host_gnt_held", gnt_o, 3'b100);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("host_gnt_clr", gnt_o, 3'b000);
    check("host_id_none", id_o, 3);

    // All three requesting with immediate READY/DONE: rotation 0,1,2 with one idle bubble.
    drain();
    for (int n = 0; n < 3; n++) begin a[n] = ADDR_W'(32'h1000 * (n + 1)); b[n] = 5'd4; end
    req = 3'b111;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (valid_o) begin ids.push_back(int'(id_o)); ts.push_back(i); end
    end
    check("rr_count", ids.size(), 7);
    for (int i = 0; i < 6 && i < ids.size(); i++) check("rr_order", ids[i], i % 3);
    for (int i = 0; i + 1 < 6 && i + 1 < ts.size(); i++) check("rr_spacing", ts[i+1] - ts[i], 3);

    // Urgent scanout rising in the same idle cycle beats pending 1 and 2 with rr_ptr=0.
    drain();
    req = 3'b001;
    tick();
    req = 3'b110;
    tick();
    tick();
    req = 3'b111; urg = 1'b1;
    tick();
    check("urgent_win", id_o, 0);

    // Requester 2 starved behind urgent scanout, wins over round-robin's choice of 1.
    drain();
    req = 3'b101; urg = 1'b1; cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (starve_o[2]) cnt++;
      if (k >= 8 && m_phase == 0) break;
    end
    urg = 1'b0; req = 3'b111;
    tick();
    if (starve_o[2]) cnt++;
    check("starve_win", id_o, 2);
    check("starve_once", cnt, 1);

    // Watchdog: DONE never arrives, abort 16 cycles into BUSY, next requester served.
    drain();
    req = 3'b110; ready = 1'b1; done = 1'b0;
    tick();
    check("to_grant", id_o, 1);
    tick();
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      cnt++;
      if (err_o) break;
    end
    check("to_cycles", cnt, TMO);
    check("to_gnt_clr", gnt_o, 3'b000);
    tick();
    check("to_next", id_o, 2);

    // Zero burst latched as 1, then reset asserted mid-BUSY.
    drain();
    req = 3'b010; b[1] = 5'd0; wr = 3'b000; a[1] = 22'h2abcd;
    tick();
    check("burst0", burst_o, 5'd1);
    ready = 1'b1;
    tick();
    ready = 1'b0; done = 1'b0; req = 3'b000;
    tick();
    check("pre_rst_gnt", gnt_o, 3'b010);
    rstn = 1'b0;
    #1;
    check("rst_gnt", gnt_o, 3'b000);
    check("rst_id", id_o, 3);
    check("rst_valid", valid_o, 1'b0);
    check("rst_addr", addr_o, 22'h0);
    check("rst_burst", burst_o, 5'd0);
    check("rst_err", err_o, 1'b0);
    model_reset();
    compare_all();
    tick();
    rstn = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) req = 3'($urandom);
      wr = 3'($urandom);
      for (int n = 0; n < 3; n++) begin
        a[n] = ADDR_W'($urandom);
        b[n] = BURST_W'($urandom_range(0, 16));
      end
      urg   = ($urandom_range(0, 3) == 0);
      ready = ($urandom_range(0, 2) != 0);
      done  = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
